game_phase_sequencer: RTL and testbench
=======================================

Name: game_phase_sequencer

Overview:
- Parametrised successor of the bomb-game main controller. Sequences NUM_PHASES puzzle phases and tracks a saturating stability score with a configurable fail penalty.
- Inserts a settle interval between phases, blocks phase clears while a random event is running, and counts failures.
- Sits between the puzzle/event blocks and game_timer. Drives game_enable and timer_reset, and supplies the phase index to the display muxes.

Parameters:
NUM_PHASES, 4, number of puzzle phases (>=1)
STAB_W, 4, width of stability and fail_count
STABILITY_INIT, 9, stability loaded at reset and at every new game
STABILITY_MAX, 9, upper saturation limit (<= 2**STAB_W-1)
FAIL_PENALTY, 1, stability decrement per fail event
SETTLE_CYCLES, 50000000, cycles spent in SETTLE between phases (>=1)

Ports:
clk  in  1  system clock, 50 MHz
sys_rst  in  1  asynchronous active-high reset
start_btn  in  1  single-cycle start/acknowledge pulse
phase_clear  in  NUM_PHASES  per-phase clear pulses
phase_fail  in  NUM_PHASES  per-phase fail pulses
event_fail  in  1  event failure pulse
recover  in  1  correct-answer/event-success pulse
event_active  in  1  level, high while any event is running
time_out  in  1  game_timer expiry pulse/level
game_state  out  3  0 IDLE, 1 ARM, 2 PLAY, 3 SETTLE, 4 CLEAR, 5 OVER
phase_idx  out  $clog2(NUM_PHASES) (min 1)  active phase, 0-based
stability  out  STAB_W  current stability
fail_count  out  STAB_W  failures this game, saturating
game_enable  out  1  high in PLAY and SETTLE
timer_reset  out  1  one-cycle pulse in ARM
phase_start  out  1  one-cycle pulse on each entry to PLAY
game_clear  out  1  level, high in CLEAR
game_over  out  1  level, high in OVER

Behaviour:
- All outputs are registered.
- On sys_rst, asynchronously and immediately:
  - state IDLE, phase_idx 0;
  - stability STABILITY_INIT, fail_count 0;
  - all pulses/levels 0, settle counter 0.
- A mid-game reset aborts the game with no residual pulse.
- IDLE: on start_btn, reload stability=STABILITY_INIT, fail_count=0, phase_idx=0, then go to ARM.
- ARM: lasts exactly 1 cycle.
  - timer_reset=1 during ARM.
  - Next cycle: PLAY, with phase_start=1 in the first PLAY cycle.
- PLAY, evaluated per cycle in this priority order:
  1. time_out: go to OVER.
  2. Fail, i.e. phase_fail[phase_idx] or event_fail:
     - stability -= FAIL_PENALTY, saturating at 0;
     - fail_count += 1, saturating;
     - if the new stability is 0, go to OVER.
     - Recover in the same cycle is ignored.
  3. recover alone: stability += 1, saturating at STABILITY_MAX.
  4. phase_clear[phase_idx] with event_active=0, and not already sent to OVER this cycle:
     - if phase_idx==NUM_PHASES-1, go to CLEAR;
     - else go to SETTLE with the settle counter cleared.
- phase_clear/phase_fail bits for other phases are ignored.
- phase_clear while event_active=1 is dropped, not queued.
- A fail and a clear in the same cycle both apply: the fail is processed first; the clear still advances if stability stays >0.
- SETTLE:
  - Counts SETTLE_CYCLES cycles.
  - time_out, event_fail and recover are handled as in PLAY. Phase fails are ignored, since no phase is active.
  - On the terminal count: phase_idx+=1, go to PLAY, phase_start=1.
- CLEAR/OVER: terminal states.
  - Stability and fail_count are frozen; game_enable=0.
  - start_btn returns to IDLE. A second start_btn starts a new game.
- IDLE ignores every input except start_btn.
- The stability update is width-safe: compute in STAB_W+1 bits before clamping.

Decomposition:
- Package game_pkg holds:
  - the state encoding constants (ST_IDLE..ST_OVER, 3 bits);
  - the STATE_W constant.
- Sub-module stability_counter contains the saturating add/sub score logic. It has the same clk/sys_rst, load/inc/dec inputs, and a penalty parameter.
- The settle counter and the FSM live in the top of this block.

Test Plan:
1. Full clear path (NUM_PHASES=4, SETTLE_CYCLES=3):
   - Stimulus: start_btn, then phase_clear bits 0,1,2,3 in turn, each pulsed after the matching phase_start.
   - Required response: the state walks IDLE→ARM→PLAY→SETTLE(3 cycles)→PLAY…→CLEAR; phase_idx is 0..3; timer_reset fires exactly once; phase_start fires 4 times; game_clear=1.
2. Stability floor (STABILITY_INIT=3, FAIL_PENALTY=2):
   - Stimulus: two event_fail pulses.
   - Required response: stability goes 3→1→0; fail_count=2; the state goes to OVER on the second fail; game_over=1.
3. Simultaneous fail and recover at stability=5:
   - Required response: stability=4 (recover ignored).
   - Then recover alone at stability=STABILITY_MAX=9 → stability stays 9.
4. Clear during an event:
   - Stimulus: event_active=1 with phase_clear[0].
   - Required response: stays in PLAY, phase_idx=0.
   - Then event_active=0 and phase_clear[0] → SETTLE. Also, phase_clear[2] while phase_idx=0 → ignored.
5. Priority checks:
   - Stimulus: time_out together with phase_clear of the last phase.
   - Required response: OVER, not CLEAR.
   - Stimulus: a fail that drops stability 1→0, together with a clear.
   - Required response: OVER.
6. Reset mid-SETTLE:
   - Stimulus: sys_rst asserted.
   - Required response: the same cycle shows state=0, phase_idx=0, stability=STABILITY_INIT, all pulses 0.
   - After release, start_btn starts a fresh game, with fail_count=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding for the phase sequencer and its bus interface.
package game_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARM    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd4;
  localparam logic [STATE_W-1:0] ST_OVER   = 3'd5;

endpackage

// File: rtl/game_phase_sequencer_if.sv
// Bus between the puzzle/event blocks and the phase sequencer.
interface game_phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int STAB_W     = 4
);
  import game_pkg::*;

  localparam int PIDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                  start_btn;
  logic [NUM_PHASES-1:0] phase_clear;
  logic [NUM_PHASES-1:0] phase_fail;
  logic                  event_fail;
  logic                  recover;
  logic                  event_active;
  logic                  time_out;

  logic [STATE_W-1:0]    game_state;
  logic [PIDX_W-1:0]     phase_idx;
  logic [STAB_W-1:0]     stability;
  logic [STAB_W-1:0]     fail_count;
  logic                  game_enable;
  logic                  timer_reset;
  logic                  phase_start;
  logic                  game_clear;
  logic                  game_over;

  modport master (
    output start_btn, phase_clear, phase_fail, event_fail, recover, event_active, time_out,
    input  game_state, phase_idx, stability, fail_count, game_enable, timer_reset,
           phase_start, game_clear, game_over
  );

  modport slave (
    input  start_btn, phase_clear, phase_fail, event_fail, recover, event_active, time_out,
    output game_state, phase_idx, stability, fail_count, game_enable, timer_reset,
           phase_start, game_clear, game_over
  );

endinterface

// File: rtl/stability_counter.sv
// Saturating stability score: load to INIT, decrement by PENALTY (floor 0), increment (ceiling MAX).
module stability_counter #(
  parameter int STAB_W  = 4,
  parameter int INIT    = 9,
  parameter int MAX     = 9,
  parameter int PENALTY = 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              load,
  input  logic              inc,
  input  logic              dec,
  output logic [STAB_W-1:0] value,
  output logic [STAB_W-1:0] value_next
);

  localparam logic [STAB_W:0] INIT_W = (STAB_W+1)'(INIT);
  localparam logic [STAB_W:0] MAX_W  = (STAB_W+1)'(MAX);
  localparam logic [STAB_W:0] PEN_W  = (STAB_W+1)'(PENALTY);
  localparam logic [STAB_W:0] ONE_W  = (STAB_W+1)'(1);

  logic [STAB_W:0] wide_next;

  // One spare bit keeps the add/sub from wrapping before the clamp.
  always_comb begin
    wide_next = {1'b0, value};
    if (load) begin
      wide_next = INIT_W;
    end else if (dec) begin
      wide_next = (wide_next < PEN_W) ? '0 : wide_next - PEN_W;
    end else if (inc) begin
      wide_next = (wide_next >= MAX_W) ? MAX_W : wide_next + ONE_W;
    end
    value_next = wide_next[STAB_W-1:0];
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      value <= INIT_W[STAB_W-1:0];
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/game_phase_sequencer.sv
// Game controller: walks NUM_PHASES puzzle phases with settle gaps, tracks stability and failures.
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int NUM_PHASES     = 4,
  parameter int STAB_W         = 4,
  parameter int STABILITY_INIT = 9,
  parameter int STABILITY_MAX  = 9,
  parameter int FAIL_PENALTY   = 1,
  parameter int SETTLE_CYCLES  = 50000000
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  game_phase_sequencer_if.slave  bus
);

  localparam int PIDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PIDX_W-1:0] LAST_PHASE  = PIDX_W'(NUM_PHASES - 1);
  localparam logic [STAB_W-1:0] FAIL_MAX    = '1;

  logic [STATE_W-1:0] state_reg, state_next;
  logic [PIDX_W-1:0]  phase_reg, phase_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [STAB_W-1:0]  fail_cnt_reg, fail_cnt_next;
  logic               timer_reset_reg, phase_start_reg, enable_reg, clear_reg, over_reg;

  logic               stab_load, stab_inc, stab_dec;
  logic [STAB_W-1:0]  stab_value, stab_next;
  logic               fail_hit, clear_hit;

  stability_counter #(
    .STAB_W  (STAB_W),
    .INIT    (STABILITY_INIT),
    .MAX     (STABILITY_MAX),
    .PENALTY (FAIL_PENALTY)
  ) u_stability (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .load       (stab_load),
    .inc        (stab_inc),
    .dec        (stab_dec),
    .value      (stab_value),
    .value_next (stab_next)
  );

  // Phase-specific pulses only count while a phase is actually being played.
  assign fail_hit  = bus.event_fail || ((state_reg == ST_PLAY) && bus.phase_fail[phase_reg]);
  assign clear_hit = (state_reg == ST_PLAY) && bus.phase_clear[phase_reg] && !bus.event_active;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    cnt_next      = cnt_reg;
    fail_cnt_next = fail_cnt_reg;
    stab_load     = 1'b0;
    stab_inc      = 1'b0;
    stab_dec      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start_btn) begin
          stab_load     = 1'b1;
          fail_cnt_next = '0;
          phase_next    = '0;
          state_next    = ST_ARM;
        end
      end
      ST_ARM: state_next = ST_PLAY;
      ST_PLAY, ST_SETTLE: begin
        if (bus.time_out) begin
          state_next = ST_OVER;
        end else begin
          if (fail_hit) begin
            stab_dec = 1'b1;
            if (fail_cnt_reg != FAIL_MAX) fail_cnt_next = fail_cnt_reg + 1'b1;
          end else if (bus.recover) begin
            stab_inc = 1'b1;
          end
          // A fail that empties stability ends the game before any advance.
          if (fail_hit && (stab_next == '0)) begin
            state_next = ST_OVER;
          end else if (state_reg == ST_PLAY) begin
            if (clear_hit) begin
              if (phase_reg == LAST_PHASE) begin
                state_next = ST_CLEAR;
              end else begin
                state_next = ST_SETTLE;
                cnt_next   = '0;
              end
            end
          end else if (cnt_reg == SETTLE_LAST) begin
            phase_next = phase_reg + 1'b1;
            state_next = ST_PLAY;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_CLEAR, ST_OVER: begin
        if (bus.start_btn) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= '0;
      cnt_reg         <= '0;
      fail_cnt_reg    <= '0;
      timer_reset_reg <= 1'b0;
      phase_start_reg <= 1'b0;
      enable_reg      <= 1'b0;
      clear_reg       <= 1'b0;
      over_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      cnt_reg         <= cnt_next;
      fail_cnt_reg    <= fail_cnt_next;
      timer_reset_reg <= (state_next == ST_ARM);
      phase_start_reg <= (state_next == ST_PLAY) && (state_reg != ST_PLAY);
      enable_reg      <= (state_next == ST_PLAY) || (state_next == ST_SETTLE);
      clear_reg       <= (state_next == ST_CLEAR);
      over_reg        <= (state_next == ST_OVER);
    end
  end

  assign bus.game_state  = state_reg;
  assign bus.phase_idx   = phase_reg;
  assign bus.stability   = stab_value;
  assign bus.fail_count  = fail_cnt_reg;
  assign bus.game_enable = enable_reg;
  assign bus.timer_reset = timer_reset_reg;
  assign bus.phase_start = phase_start_reg;
  assign bus.game_clear  = clear_reg;
  assign bus.game_over   = over_reg;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed and randomized checks of game_phase_sequencer against a rule-level reference model.
module tb_game_phase_sequencer;

  localparam int NP  = 4;
  localparam int SW  = 4;
  localparam int SI  = 7;
  localparam int SM  = 9;
  localparam int PEN = 2;
  localparam int SC  = 3;

  localparam int S_IDLE = 0, S_ARM = 1, S_PLAY = 2, S_SETTLE = 3, S_CLEAR = 4, S_OVER = 5;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  game_phase_sequencer_if #(.NUM_PHASES(NP), .STAB_W(SW)) bus ();

  game_phase_sequencer #(
    .NUM_PHASES     (NP),
    .STAB_W         (SW),
    .STABILITY_INIT (SI),
    .STABILITY_MAX  (SM),
    .FAIL_PENALTY   (PEN),
    .SETTLE_CYCLES  (SC)
  ) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tr_seen, ps_seen;

  int m_state, m_phase, m_stab, m_fails, m_left;
  bit m_tr, m_ps;

  task automatic model_reset();
    m_state = S_IDLE; m_phase = 0; m_stab = SI; m_fails = 0; m_left = 0;
    m_tr = 0; m_ps = 0;
  endtask

  // One clock of the game rules, applied to the inputs present at that edge.
  task automatic model_step(input bit s, input bit [NP-1:0] c, input bit [NP-1:0] f,
                            input bit e, input bit r, input bit a, input bit t);
    int fmax;
    bit failed;
    fmax = (1 << SW) - 1;
    m_ps = 0;
    case (m_state)
      S_IDLE: if (s) begin
        m_stab = SI; m_fails = 0; m_phase = 0; m_state = S_ARM;
      end
      S_ARM: begin m_state = S_PLAY; m_ps = 1; end
      S_PLAY, S_SETTLE: begin
        if (t) m_state = S_OVER;
        else begin
          failed = e || (m_state == S_PLAY && f[m_phase]);
          if (failed) begin
            m_stab  = (m_stab > PEN) ? m_stab - PEN : 0;
            m_fails = (m_fails < fmax) ? m_fails + 1 : fmax;
            if (m_stab == 0) m_state = S_OVER;
          end else if (r) begin
            m_stab = (m_stab < SM) ? m_stab + 1 : SM;
          end
          if (m_state == S_PLAY) begin
            if (c[m_phase] && !a) begin
              if (m_phase == NP - 1) m_state = S_CLEAR;
              else begin m_state = S_SETTLE; m_left = SC; end
            end
          end else if (m_state == S_SETTLE) begin
            m_left--;
            if (m_left == 0) begin m_phase++; m_state = S_PLAY; m_ps = 1; end
          end
        end
      end
      default: if (s) m_state = S_IDLE;
    endcase
    m_tr = (m_state == S_ARM);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",       bus.game_state,  m_state);
    check("phase_idx",   bus.phase_idx,   m_phase);
    check("stability",   bus.stability,   m_stab);
    check("fail_count",  bus.fail_count,  m_fails);
    check("game_enable", bus.game_enable, int'(m_state == S_PLAY || m_state == S_SETTLE));
    check("timer_reset", bus.timer_reset, int'(m_tr));
    check("phase_start", bus.phase_start, int'(m_ps));
    check("game_clear",  bus.game_clear,  int'(m_state == S_CLEAR));
    check("game_over",   bus.game_over,   int'(m_state == S_OVER));
  endtask

  task automatic step(input bit s, input bit [NP-1:0] c, input bit [NP-1:0] f,
                      input bit e, input bit r, input bit a, input bit t);
    bus.start_btn = s; bus.phase_clear = c; bus.phase_fail = f;
    bus.event_fail = e; bus.recover = r; bus.event_active = a; bus.time_out = t;
    @(posedge clk);
    model_step(s, c, f, e, r, a, t);
    #1;
    check_all();
    tr_seen += int'(bus.timer_reset);
    ps_seen += int'(bus.phase_start);
    $display("step s=%0b c=%b f=%b e=%0b r=%0b a=%0b t=%0b -> state=%0d idx=%0d stab=%0d fails=%0d",
             s, c, f, e, r, a, t, bus.game_state, bus.phase_idx, bus.stability, bus.fail_count);
  endtask

  task automatic idle_step();
    step(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    sys_rst = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    bus.start_btn = 0; bus.phase_clear = '0; bus.phase_fail = '0;
    bus.event_fail = 0; bus.recover = 0; bus.event_active = 0; bus.time_out = 0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    sys_rst = 1'b0;

    // Full clear path through all phases.
    tr_seen = 0; ps_seen = 0;
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    for (int p = 0; p < NP; p++) begin
      step(0, NP'(1 << p), '0, 0, 0, 0, 0);
      if (p < NP - 1) repeat (SC) idle_step();
    end
    check("t1_timer_reset_count", tr_seen, 1);
    check("t1_phase_start_count", ps_seen, NP);
    check("t1_game_clear", bus.game_clear, 1);

    // Stability floor with a penalty of 2: 7,5,3,1,0.
    step(1, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    repeat (4) step(0, '0, '0, 1, 0, 0, 0);
    check("t2_stability", bus.stability, 0);
    check("t2_fail_count", bus.fail_count, 4);
    check("t2_game_over", bus.game_over, 1);

    // Fail with recover, then recover saturation.
    step(1, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    step(0, '0, '0, 1, 0, 0, 0);
    check("t3_stab_after_fail", bus.stability, 5);
    step(0, '0, '0, 1, 1, 0, 0);
    check("t3_recover_ignored", bus.stability, 3);
    repeat (7) step(0, '0, '0, 0, 1, 0, 0);
    check("t3_stab_ceiling", bus.stability, SM);

    // Clears during an event and for a foreign phase are dropped.
    step(0, 4'b0001, '0, 0, 0, 1, 0);
    check("t4_event_blocks", bus.game_state, S_PLAY);
    step(0, 4'b0100, '0, 0, 0, 0, 0);
    check("t4_other_phase", bus.game_state, S_PLAY);
    step(0, 4'b0001, '0, 0, 0, 0, 0);
    check("t4_settle", bus.game_state, S_SETTLE);

    // Time-out beats the last clear; a fatal fail beats a clear.
    repeat (SC) idle_step();
    step(0, 4'b0010, '0, 0, 0, 0, 0);
    repeat (SC) idle_step();
    step(0, 4'b0100, '0, 0, 0, 0, 0);
    repeat (SC) idle_step();
    check("t5_last_phase", bus.phase_idx, NP - 1);
    step(0, 4'b1000, '0, 0, 0, 0, 1);
    check("t5_timeout_over", bus.game_state, S_OVER);
    step(1, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    repeat (3) step(0, '0, '0, 1, 0, 0, 0);
    step(0, 4'b0001, 4'b0001, 0, 0, 0, 0);
    check("t5_fail_beats_clear", bus.game_state, S_OVER);

    // Reset in the middle of SETTLE.
    step(1, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    step(0, '0, '0, 1, 0, 0, 0);
    step(0, 4'b0001, '0, 0, 0, 0, 0);
    idle_step();
    async_reset();
    check("t6_reset_state", bus.game_state, S_IDLE);
    step(1, '0, '0, 0, 0, 0, 0);
    idle_step();
    check("t6_fresh_fail_count", bus.fail_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(9) == 0,
             NP'($urandom & $urandom),
             NP'($urandom & $urandom & $urandom),
             $urandom_range(19) == 0,
             $urandom_range(5) == 0,
             $urandom_range(3) == 0,
             $urandom_range(59) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
